// File: rtl/draw_arbiter.sv
// Round-robin arbiter for three sprite requesters (two paddles, one ball) feeding a
// single box drawer: each accepted request becomes an optional erase box plus a draw box.
module draw_arbiter #(
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [26:0] req_old_x,
  input  logic [26:0] req_new_x,
  input  logic [23:0] req_old_y,
  input  logic [23:0] req_new_y,
  input  logic [26:0] req_w,
  input  logic [23:0] req_h,
  input  logic [8:0]  req_colour,
  input  logic [2:0]  req_skip_erase,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [8:0]  out_box_x,
  output logic [7:0]  out_box_y,
  output logic [8:0]  out_box_w,
  output logic [7:0]  out_box_h,
  output logic [2:0]  out_box_color,
  output logic [2:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ERASE = 2'b01,
    DRAW  = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  last_ptr_r;
  logic [2:0]  grant_r;
  logic [8:0]  old_x_r;
  logic [7:0]  old_y_r;
  logic [8:0]  new_x_r;
  logic [7:0]  new_y_r;
  logic [8:0]  w_r;
  logic [7:0]  h_r;
  logic [2:0]  colour_r;

  logic [1:0]  cand_s;
  logic        hit_s;
  logic        win_found_s;
  logic [1:0]  win_idx_s;
  logic        accept_s;
  logic        xfer_s;
  logic [2:0]  req_ready_s;

  logic [8:0]  sel_old_x_s;
  logic [7:0]  sel_old_y_s;
  logic [8:0]  sel_new_x_s;
  logic [7:0]  sel_new_y_s;
  logic [8:0]  sel_w_s;
  logic [7:0]  sel_h_s;
  logic [2:0]  sel_colour_s;
  logic        sel_skip_s;

  function automatic logic [1:0] inc3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 2'd0;
    hit_s       = 1'b0;
    cand_s      = inc3(last_ptr_r);
    for (int k = 0; k < 3; k++) begin
      hit_s       = !win_found_s && req_valid[cand_s];
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
      cand_s      = inc3(cand_s);
    end
  end

  // Unpack the winner's fields from the packed request buses.
  always_comb begin
    sel_old_x_s  = 9'd0;
    sel_old_y_s  = 8'd0;
    sel_new_x_s  = 9'd0;
    sel_new_y_s  = 8'd0;
    sel_w_s      = 9'd0;
    sel_h_s      = 8'd0;
    sel_colour_s = 3'd0;
    sel_skip_s   = 1'b0;
    case (win_idx_s)
      2'd0: begin
        sel_old_x_s  = req_old_x[8:0];
        sel_old_y_s  = req_old_y[7:0];
        sel_new_x_s  = req_new_x[8:0];
        sel_new_y_s  = req_new_y[7:0];
        sel_w_s      = req_w[8:0];
        sel_h_s      = req_h[7:0];
        sel_colour_s = req_colour[2:0];
        sel_skip_s   = req_skip_erase[0];
      end
      2'd1: begin
        sel_old_x_s  = req_old_x[17:9];
        sel_old_y_s  = req_old_y[15:8];
        sel_new_x_s  = req_new_x[17:9];
        sel_new_y_s  = req_new_y[15:8];
        sel_w_s      = req_w[17:9];
        sel_h_s      = req_h[15:8];
        sel_colour_s = req_colour[5:3];
        sel_skip_s   = req_skip_erase[1];
      end
      2'd2: begin
        sel_old_x_s  = req_old_x[26:18];
        sel_old_y_s  = req_old_y[23:16];
        sel_new_x_s  = req_new_x[26:18];
        sel_new_y_s  = req_new_y[23:16];
        sel_w_s      = req_w[26:18];
        sel_h_s      = req_h[23:16];
        sel_colour_s = req_colour[8:6];
        sel_skip_s   = req_skip_erase[2];
      end
      default: begin
        sel_skip_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; the accept strobe exists only while idle.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    req_ready_s  = 3'b000;
    xfer_s       = m_ready && (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          accept_s     = 1'b1;
          req_ready_s  = onehot3(win_idx_s);
          state_next_s = sel_skip_s ? DRAW : ERASE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ERASE: begin
        if (xfer_s) begin
          state_next_s = DRAW;
        end else begin
          state_next_s = ERASE;
        end
      end
      DRAW: begin
        if (xfer_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAW;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // A requester must never see an accept while the block is held in reset.
  assign req_ready = req_ready_s & {3{reset_n}};

  // State register and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      last_ptr_r <= 2'd2;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        last_ptr_r <= win_idx_s;
      end
    end
  end

  // Transaction capture, so later requester activity cannot disturb it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      old_x_r  <= 9'd0;
      old_y_r  <= 8'd0;
      new_x_r  <= 9'd0;
      new_y_r  <= 8'd0;
      w_r      <= 9'd0;
      h_r      <= 8'd0;
      colour_r <= 3'd0;
    end else if (accept_s) begin
      old_x_r  <= sel_old_x_s;
      old_y_r  <= sel_old_y_s;
      new_x_r  <= sel_new_x_s;
      new_y_r  <= sel_new_y_s;
      w_r      <= sel_w_s;
      h_r      <= sel_h_s;
      colour_r <= sel_colour_s;
    end
  end

  // Owner of the in-flight transaction; cleared once the draw box is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_r <= 3'b000;
    end else if (accept_s) begin
      grant_r <= onehot3(win_idx_s);
    end else if ((state_r == DRAW) && xfer_s) begin
      grant_r <= 3'b000;
    end
  end

  // Box command is a pure decode of registered state, so it holds while stalled.
  always_comb begin
    m_valid       = 1'b0;
    out_box_x     = 9'd0;
    out_box_y     = 8'd0;
    out_box_w     = 9'd0;
    out_box_h     = 8'd0;
    out_box_color = 3'd0;
    case (state_r)
      ERASE: begin
        m_valid       = 1'b1;
        out_box_x     = old_x_r;
        out_box_y     = old_y_r;
        out_box_w     = w_r;
        out_box_h     = h_r;
        out_box_color = ERASE_COLOUR;
      end
      DRAW: begin
        m_valid       = 1'b1;
        out_box_x     = new_x_r;
        out_box_y     = new_y_r;
        out_box_w     = w_r;
        out_box_h     = h_r;
        out_box_color = colour_r;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  assign busy  = (state_r != IDLE);
  assign grant = grant_r;

endmodule

// File: tb/tb_draw_arbiter.sv
// Checks draw_arbiter against a queue-of-boxes model: each accept enqueues the
// erase/draw boxes it owes, and the head of the queue is what m_valid must offer.
module tb_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [26:0] req_old_x, req_new_x, req_w;
  logic [23:0] req_old_y, req_new_y, req_h;
  logic [8:0]  req_colour;
  logic [2:0]  req_skip_erase;
  logic        m_valid, m_ready;
  logic [8:0]  out_box_x, out_box_w;
  logic [7:0]  out_box_y, out_box_h;
  logic [2:0]  out_box_color, grant;
  logic        busy;

  draw_arbiter #(.ERASE_COLOUR(3'b000)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_old_x(req_old_x), .req_new_x(req_new_x), .req_old_y(req_old_y), .req_new_y(req_new_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .req_skip_erase(req_skip_erase),
    .m_valid(m_valid), .m_ready(m_ready), .out_box_x(out_box_x), .out_box_y(out_box_y),
    .out_box_w(out_box_w), .out_box_h(out_box_h), .out_box_color(out_box_color),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: boxes still owed to the drawer, owner, last served requester.
  logic [36:0] pend[$];
  logic [2:0]  own;
  int          last_ptr;

  // Hand-written expectations for directed cycles.
  logic        pin_en = 1'b0;
  logic [2:0]  pin_rdy, pin_grant;
  logic        pin_mv, pin_busy, pin_box_en;
  logic [36:0] pin_box;

  function automatic logic [36:0] box(input logic [8:0] x, input logic [7:0] y,
                                      input logic [8:0] w, input logic [7:0] h,
                                      input logic [2:0] c);
    return {x, y, w, h, c};
  endfunction

  function automatic int pick(input logic [2:0] v, input int lp);
    for (int k = 1; k <= 3; k++) begin
      if (v[(lp + k) % 3]) return (lp + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    own = 3'b000;
    last_ptr = 2;
  endtask

  task automatic model_step();
    int w;
    if (!reset_n) begin
      model_reset();
    end else if (pend.size() == 0) begin
      w = pick(req_valid, last_ptr);
      if (w >= 0) begin
        if (!req_skip_erase[w])
          pend.push_back(box(req_old_x[9*w +: 9], req_old_y[8*w +: 8],
                             req_w[9*w +: 9], req_h[8*w +: 8], 3'b000));
        pend.push_back(box(req_new_x[9*w +: 9], req_new_y[8*w +: 8],
                           req_w[9*w +: 9], req_h[8*w +: 8], req_colour[3*w +: 3]));
        own = 3'(1 << w);
        last_ptr = w;
      end
    end else if (m_ready) begin
      void'(pend.pop_front());
      if (pend.size() == 0) own = 3'b000;
    end
  endtask

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of DUT against the model, plus model/DUT against pins.
  always @(negedge clock) begin
    logic [2:0]  exp_rdy;
    logic [36:0] act_box;
    logic        exp_mv;
    int          w;
    exp_rdy = 3'b000;
    if (reset_n && pend.size() == 0) begin
      w = pick(req_valid, last_ptr);
      if (w >= 0) exp_rdy = 3'(1 << w);
    end
    exp_mv  = (pend.size() != 0);
    act_box = {out_box_x, out_box_y, out_box_w, out_box_h, out_box_color};
    chk("req_ready", 37'(req_ready), 37'(exp_rdy));
    chk("m_valid", 37'(m_valid), 37'(exp_mv));
    chk("busy", 37'(busy), 37'(exp_mv));
    chk("grant", 37'(grant), 37'(own));
    if (exp_mv) chk("out_box", act_box, pend[0]);
    else if (!reset_n) chk("out_box_reset", act_box, 37'd0);
    if (pin_en) begin
      chk("pin_req_ready", 37'(req_ready), 37'(pin_rdy));
      chk("pin_m_valid", 37'(m_valid), 37'(pin_mv));
      chk("pin_busy", 37'(busy), 37'(pin_busy));
      chk("pin_grant", 37'(grant), 37'(pin_grant));
      chk("model_req_ready", 37'(exp_rdy), 37'(pin_rdy));
      chk("model_m_valid", 37'(exp_mv), 37'(pin_mv));
      if (pin_box_en) begin
        chk("pin_out_box", act_box, pin_box);
        if (exp_mv) chk("model_out_box", pend[0], pin_box);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    pin_en = 1'b0;
  endtask

  task automatic pin(input logic [2:0] rdy, input logic mv, input logic bz,
                     input logic [2:0] gr, input logic be, input logic [36:0] bx);
    pin_en = 1'b1; pin_rdy = rdy; pin_mv = mv; pin_busy = bz;
    pin_grant = gr; pin_box_en = be; pin_box = bx;
  endtask

  task automatic set_req(input int i, input logic [8:0] ox, input logic [7:0] oy,
                         input logic [8:0] nx, input logic [7:0] ny,
                         input logic [8:0] w, input logic [7:0] h,
                         input logic [2:0] c, input logic sk);
    req_old_x[9*i +: 9] = ox; req_old_y[8*i +: 8] = oy;
    req_new_x[9*i +: 9] = nx; req_new_y[8*i +: 8] = ny;
    req_w[9*i +: 9] = w; req_h[8*i +: 8] = h;
    req_colour[3*i +: 3] = c; req_skip_erase[i] = sk;
  endtask

  initial begin
    logic [2:0] g;
    reset_n = 1'b0; m_ready = 1'b0; req_valid = 3'b000;
    req_old_x = 27'd0; req_new_x = 27'd0; req_w = 27'd0;
    req_old_y = 24'd0; req_new_y = 24'd0; req_h = 24'd0;
    req_colour = 9'd0; req_skip_erase = 3'b000;
    model_reset();
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 37'd0); tick();
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 37'd0); tick();
    reset_n = 1'b1;

    // single erase+draw transaction from requester 0
    set_req(0, 9'd10, 8'd20, 9'd12, 8'd20, 9'd4, 8'd16, 3'b111, 1'b0);
    req_valid = 3'b001; m_ready = 1'b1;
    pin(3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();
    req_valid = 3'b000;
    pin(3'b000, 1'b1, 1'b1, 3'b001, 1'b1, box(9'd10, 8'd20, 9'd4, 8'd16, 3'b000)); tick();
    pin(3'b000, 1'b1, 1'b1, 3'b001, 1'b1, box(9'd12, 8'd20, 9'd4, 8'd16, 3'b111)); tick();
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();

    // all requesters held valid: round-robin 0,1,2,0 with three cycles per grant
    reset_n = 1'b0; model_reset();
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 37'd0); tick();
    reset_n = 1'b1;
    set_req(1, 9'd200, 8'd100, 9'd201, 8'd101, 9'd8, 8'd32, 3'b011, 1'b0);
    set_req(2, 9'd50, 8'd60, 9'd52, 8'd62, 9'd4, 8'd4, 3'b110, 1'b0);
    req_valid = 3'b111;
    for (int j = 0; j < 4; j++) begin
      g = 3'b001 << (j % 3);
      pin(g, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();
      pin(3'b000, 1'b1, 1'b1, g, 1'b0, 37'd0); tick();
      pin(3'b000, 1'b1, 1'b1, g, 1'b0, 37'd0); tick();
    end
    req_valid = 3'b000;
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();

    // skip_erase on requester 2: a single draw box
    set_req(2, 9'd0, 8'd0, 9'd80, 8'd60, 9'd4, 8'd4, 3'b010, 1'b1);
    req_valid = 3'b100;
    pin(3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();
    req_valid = 3'b000;
    pin(3'b000, 1'b1, 1'b1, 3'b100, 1'b1, box(9'd80, 8'd60, 9'd4, 8'd4, 3'b010)); tick();
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();

    // stall during erase and modify the requester's new_x mid-flight
    set_req(0, 9'd30, 8'd40, 9'd100, 8'd50, 9'd8, 8'd8, 3'b101, 1'b0);
    req_valid = 3'b001; m_ready = 1'b0;
    pin(3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();
    req_valid = 3'b000; req_new_x[8:0] = 9'd300;
    for (int k = 0; k < 5; k++) begin
      pin(3'b000, 1'b1, 1'b1, 3'b001, 1'b1, box(9'd30, 8'd40, 9'd8, 8'd8, 3'b000)); tick();
    end
    m_ready = 1'b1;
    pin(3'b000, 1'b1, 1'b1, 3'b001, 1'b1, box(9'd30, 8'd40, 9'd8, 8'd8, 3'b000)); tick();
    m_ready = 1'b0;
    pin(3'b000, 1'b1, 1'b1, 3'b001, 1'b1, box(9'd100, 8'd50, 9'd8, 8'd8, 3'b101)); tick();

    // reset during a stalled draw, then requester 1 must win first
    reset_n = 1'b0; model_reset(); req_valid = 3'b110;
    pin(3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 37'd0); tick();
    reset_n = 1'b1;
    pin(3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 37'd0); tick();
    req_valid = 3'b000; m_ready = 1'b1;
    tick(); tick(); tick();

    // randomized traffic, including field churn and occasional resets
    for (int c = 0; c < 4000; c++) begin
      req_valid      = 3'($urandom);
      req_old_x      = 27'($urandom); req_new_x = 27'($urandom); req_w = 27'($urandom);
      req_old_y      = 24'($urandom); req_new_y = 24'($urandom); req_h = 24'($urandom);
      req_colour     = 9'($urandom);
      req_skip_erase = 3'($urandom);
      m_ready        = ($urandom_range(0, 3) != 0);
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
